// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encodings and direction constants for the programmable timer
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } timer_state_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler producing a tick strobe every TICK_DIV running cycles
module tick_gen #(
    parameter int TICK_DIV = 1_000_000,
    parameter int PS_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic sync_clr,
    output logic tick
);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    logic [PS_W-1:0] ps_q;
    logic [PS_W-1:0] ps_d;

    // Strobe is high on the edge where the prescaler rolls over; the owner registers its effects.
    assign tick = run && (ps_q == PS_LAST);

    // Next prescaler value: held when not running so a paused period resumes where it stopped.
    always_comb begin
        ps_d = ps_q;
        if (sync_clr) begin
            ps_d = '0;
        end else if (run) begin
            ps_d = (ps_q == PS_LAST) ? '0 : ps_q + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

endmodule

// File: rtl/prog_timer.sv
// rtl/prog_timer.sv - prescaled up/down tick counter with wrap/saturate modes and status pulses
module prog_timer
    import timer_pkg::*;
#(
    parameter int CNT_W    = 7,
    parameter int TICK_DIV = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dir,
    input  logic             wrap_en,
    input  logic [CNT_W-1:0] cmp_val,
    output logic [CNT_W-1:0] time_count,
    output logic             tick,
    output logic             match,
    output logic             wrap,
    output logic             done,
    output logic [1:0]       state
);

    localparam int               PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    timer_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             match_q, match_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             ps_tick;

    tick_gen #(
        .TICK_DIV (TICK_DIV),
        .PS_W     (PS_W)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (state_q == ST_RUN),
        .sync_clr (clear | load),
        .tick     (ps_tick)
    );

    // Next-state, count and flag logic: clear beats load, load beats any tick on the same edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        match_d = 1'b0;
        wrap_d  = 1'b0;
        done_d  = done_q;
        if (clear) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
        end else if (load) begin
            cnt_d   = load_val;
            done_d  = 1'b0;
            state_d = enable ? ST_RUN : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (enable)  state_d = ST_RUN;
                ST_RUN:   if (!enable) state_d = ST_PAUSE;
                ST_PAUSE: if (enable)  state_d = ST_RUN;
                default:  state_d = ST_DONE;
            endcase
            // ps_tick only fires in RUN, so a tick landing as enable falls is still applied.
            if (ps_tick) begin
                tick_d = 1'b1;
                if (dir == DIR_UP) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end else if (wrap_en) begin
                        cnt_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (wrap_en) begin
                        cnt_d  = CNT_MAX;
                        wrap_d = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
                match_d = (cnt_d != cnt_q) && (cnt_d == cmp_val);
            end
        end
    end

    // State, count and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            match_q <= 1'b0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            match_q <= match_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign time_count = cnt_q;
    assign tick       = tick_q;
    assign match      = match_q;
    assign wrap       = wrap_q;
    assign done       = done_q;
    assign state      = state_q;

endmodule
